rf_access_scheduler: RTL
========================

# rf_access_scheduler

Arbitrates access to the warp-banked `register_block` between the writeback unit (one write request) and the operand fetch stage (one two-operand read request). `register_block` has one shared `warp_selector`, so a write and a read can issue in the same cycle only when both target the same warp. This block picks the winner, drives all `register_block` controls, and registers the read result. It forwards same-cycle write data into reads, and uses a starvation counter so that reads always make progress.

## Interface
Parameters:
- NUM_LANES, 16, lanes per warp (width of lane masks and enables)
- NUM_WARPS, 16, warps (WARP_W = clog2 = 4)
- NUM_REGS, 32, registers per lane (ADDR_W = 5)
- DATA_W, 32, bits per lane register
- STARVE_MAX, 4, consecutive lost read cycles before a read is forced to win (1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid / wb_ready  in / out  1  write request handshake
- wb_warp, wb_addr, wb_mask  in  4, 5, 16  target warp, register, lane mask
- wb_data  in  512  lane i occupies bits [32i+31:32i]
- rd_valid / rd_ready  in / out  1  read request handshake
- rd_warp, rd_addr_0, rd_addr_1, rd_mask  in  4, 5, 5, 16  read warp, two source registers, lane mask
- rsp_valid  out  1  one-cycle pulse, read data available
- rsp_warp  out  4  warp of the response
- rsp_data_0, rsp_data_1  out  512  operand data, packed like wb_data
- rb_warp_selector  out  4  to register_block warp_selector
- rb_write_en, rb_read_en_0, rb_read_en_1  out  16  per-lane enables
- rb_waddr, rb_raddr_0, rb_raddr_1  out  5  addresses
- rb_wdata  out  512  split to wdata_0..15
- rb_rdata_0, rb_rdata_1  in  512  packed from rdata_0_i / rdata_1_i (combinational read)

## Operation
- A transfer occurs when valid and ready are both high in the same cycle. Ready is a combinational function of both valids and the starvation counter.
- Grant decision each cycle:
  - Only wb_valid: grant the write.
  - Only rd_valid: grant the read.
  - Both valid, wb_warp == rd_warp: grant both.
  - Both valid, warps differ: the write wins, unless starve_cnt == STARVE_MAX, in which case the read wins.
- starve_cnt (4 bits):
  - Increments in each cycle a valid read loses.
  - Clears on any read grant.
  - Saturates at STARVE_MAX.
- Register_block drive (combinational from the grant):
  - rb_warp_selector = granted warp. With no grant it holds last_warp, a register updated on every grant.
  - rb_write_en = wb_mask when the write is granted, else 0.
  - rb_read_en_p = rd_mask when the read is granted, else 0.
  - Addresses and wdata pass straight through.
- Response: on a read grant, capture rsp_data_p for every lane i:
  - rd_mask[i] == 0: capture 0.
  - Write granted in the same cycle, rd_addr_p == wb_addr and wb_mask[i] == 1: capture the wb_data lane (forwarding).
  - Otherwise: capture the rb_rdata_p lane.
- Both ports may name the same register; each port forwards independently.
- There is no response backpressure; the consumer must accept rsp_valid.

## Timing
- Write latency: data is in the array at the rising edge that completes the wb handshake.
- Read latency: rsp_valid is high exactly 1 cycle after the rd handshake. Back-to-back reads give back-to-back pulses.
- Reset: the following are cleared asynchronously, and an in-flight response is dropped:
  - rsp_valid = 0, rsp_warp = 0, rsp_data_* = 0
  - starve_cnt = 0, last_warp = 0
  - all rb enables = 0, rb_warp_selector = 0
  - both readies = 0 while rst_n is low
- Worst-case read wait under continuous different-warp writes: STARVE_MAX cycles; the grant comes on cycle STARVE_MAX+1.
- Write wait: a write waits at most 1 cycle, only in the forced-read cycle.
- Request fields must be stable while valid is high and ready is low.

## Structure
- Package rf_sched_pkg holds:
  - NUM_LANES, NUM_WARPS, NUM_REGS, DATA_W, WARP_W, ADDR_W
  - grant_e enum {GNT_NONE, GNT_WR, GNT_RD, GNT_BOTH}
  - lane slice helper function
- Sub-module rf_fwd_mux performs per-port lane selection (mask, forward, array data). It is instantiated twice.
- The top holds the grant logic, starve_cnt, last_warp and the response registers.

## Test plan
- Write warp 3, reg 7, all lanes 0xA5A5_0000+i; then read warp 3, rd_addr_0=rd_addr_1=7 -> rsp_valid 1 cycle later, both ports return 0xA5A5_0000+i, rsp_warp=3.
- Same cycle: write warp 2, reg 4, mask 0x00FF, data 0x1111_1111; read warp 2, reg 4 (old value 0x2222_2222) -> both granted, lanes 0-7 = 0x1111_1111, lanes 8-15 = 0x2222_2222.
- Continuous writes to warp 1 with a read pending on warp 5, STARVE_MAX=4 -> rd_ready is low for 4 cycles and high on the 5th, wb_ready is low in that cycle, starve_cnt returns to 0.
- Read with rd_mask=0x0001 -> lane 0 holds data, lanes 1-15 return 0; rb_read_en_0 = rb_read_en_1 = 0x0001.
- Idle after a grant to warp 9 -> rb_warp_selector stays 9 and all enables are 0.
- Assert rst_n low the cycle after a read grant -> rsp_valid never pulses; after release, readies recover and starve_cnt = 0.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// Shared geometry, grant encoding and lane helper for the register-file
// access scheduler.
package rf_sched_pkg;

  localparam int NUM_LANES = 16;
  localparam int NUM_WARPS = 16;
  localparam int NUM_REGS  = 32;
  localparam int DATA_W    = 32;
  localparam int WARP_W    = $clog2(NUM_WARPS);
  localparam int ADDR_W    = $clog2(NUM_REGS);
  localparam int BUS_W     = NUM_LANES * DATA_W;

  // Outcome of the per-cycle arbitration between writeback and operand fetch.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2,
    GNT_BOTH = 2'd3
  } grant_e;

  // Extract one lane word from a packed lane bus (lane i at [DATA_W*i +: DATA_W]).
  function automatic logic [DATA_W-1:0] lane_slice(input logic [BUS_W-1:0] bus,
                                                   input int lane);
    return bus[lane*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/rf_fwd_mux.sv
// Per-port lane selection for a read operand: masked lanes read as zero,
// lanes being written by a same-cycle write to the same register take the
// write data, all other lanes take the register_block array data.
module rf_fwd_mux
  import rf_sched_pkg::*;
(
  input  logic                 fwd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [NUM_LANES-1:0] rd_mask,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [NUM_LANES-1:0] wb_mask,
  input  logic [BUS_W-1:0]     wb_data,
  input  logic [BUS_W-1:0]     rb_rdata,
  output logic [BUS_W-1:0]     lane_data
);

  // Forwarding only applies when the write is issued alongside this read
  // and both name the same register; the warp match is implied by the grant.
  logic addr_hit;

  assign addr_hit = fwd_en && (rd_addr == wb_addr);

  // Select each lane independently from mask, forward hit and array data.
  always_comb begin
    lane_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!rd_mask[i]) begin
        lane_data[i*DATA_W +: DATA_W] = '0;
      end else if (addr_hit && wb_mask[i]) begin
        lane_data[i*DATA_W +: DATA_W] = lane_slice(wb_data, i);
      end else begin
        lane_data[i*DATA_W +: DATA_W] = lane_slice(rb_rdata, i);
      end
    end
  end

endmodule

// File: rtl/rf_access_scheduler.sv
// Arbitrates the warp-banked register_block between one writeback write and
// one two-operand operand-fetch read. The single warp_selector means a write
// and a read only share a cycle when they target the same warp; otherwise the
// write wins unless the read has starved for STARVE_MAX cycles. Read data is
// registered with same-cycle write forwarding and returned one cycle later.
module rf_access_scheduler #(
  parameter  int NUM_LANES  = 16,
  parameter  int NUM_WARPS  = 16,
  parameter  int NUM_REGS   = 32,
  parameter  int DATA_W     = 32,
  parameter  int STARVE_MAX = 4,
  localparam int WARP_W     = $clog2(NUM_WARPS),
  localparam int ADDR_W     = $clog2(NUM_REGS),
  localparam int BUS_W      = NUM_LANES * DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // writeback request
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [WARP_W-1:0]    wb_warp,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [NUM_LANES-1:0] wb_mask,
  input  logic [BUS_W-1:0]     wb_data,
  // operand fetch request
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [WARP_W-1:0]    rd_warp,
  input  logic [ADDR_W-1:0]    rd_addr_0,
  input  logic [ADDR_W-1:0]    rd_addr_1,
  input  logic [NUM_LANES-1:0] rd_mask,
  // read response
  output logic                 rsp_valid,
  output logic [WARP_W-1:0]    rsp_warp,
  output logic [BUS_W-1:0]     rsp_data_0,
  output logic [BUS_W-1:0]     rsp_data_1,
  // register_block controls
  output logic [WARP_W-1:0]    rb_warp_selector,
  output logic [NUM_LANES-1:0] rb_write_en,
  output logic [NUM_LANES-1:0] rb_read_en_0,
  output logic [NUM_LANES-1:0] rb_read_en_1,
  output logic [ADDR_W-1:0]    rb_waddr,
  output logic [ADDR_W-1:0]    rb_raddr_0,
  output logic [ADDR_W-1:0]    rb_raddr_1,
  output logic [BUS_W-1:0]     rb_wdata,
  input  logic [BUS_W-1:0]     rb_rdata_0,
  input  logic [BUS_W-1:0]     rb_rdata_1
);

  import rf_sched_pkg::*;

  grant_e              grant;
  logic                wr_gnt;
  logic                rd_gnt;
  logic                fwd_en;
  logic                starve_forced;
  logic [3:0]          starve_cnt;
  logic [WARP_W-1:0]   last_warp;
  logic [BUS_W-1:0]    fwd_data_0;
  logic [BUS_W-1:0]    fwd_data_1;

  // The read is forced through once it has lost STARVE_MAX cycles in a row.
  assign starve_forced = (starve_cnt == 4'(STARVE_MAX));

  // Grant decision; nothing is granted while reset is asserted so readies
  // and enables stay low.
  always_comb begin
    grant = GNT_NONE;
    if (rst_n) begin
      if (wb_valid && rd_valid) begin
        if (wb_warp == rd_warp) begin
          grant = GNT_BOTH;
        end else if (starve_forced) begin
          grant = GNT_RD;
        end else begin
          grant = GNT_WR;
        end
      end else if (wb_valid) begin
        grant = GNT_WR;
      end else if (rd_valid) begin
        grant = GNT_RD;
      end
    end
  end

  assign wr_gnt = (grant == GNT_WR) || (grant == GNT_BOTH);
  assign rd_gnt = (grant == GNT_RD) || (grant == GNT_BOTH);
  assign fwd_en = (grant == GNT_BOTH);

  assign wb_ready = wr_gnt;
  assign rd_ready = rd_gnt;

  // Drive register_block from the grant; the selector parks on the last
  // granted warp when idle so it does not toggle needlessly.
  always_comb begin
    rb_warp_selector = last_warp;
    if (wr_gnt) begin
      rb_warp_selector = wb_warp;
    end else if (rd_gnt) begin
      rb_warp_selector = rd_warp;
    end
    rb_write_en  = wr_gnt ? wb_mask : '0;
    rb_read_en_0 = rd_gnt ? rd_mask : '0;
    rb_read_en_1 = rd_gnt ? rd_mask : '0;
  end

  assign rb_waddr   = wb_addr;
  assign rb_raddr_0 = rd_addr_0;
  assign rb_raddr_1 = rd_addr_1;
  assign rb_wdata   = wb_data;

  // Count consecutive cycles a valid read loses; any read grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (rd_gnt) begin
      starve_cnt <= '0;
    end else if (rd_valid && !starve_forced) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Remember the warp of the most recent grant for the idle selector value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_warp <= '0;
    end else if (grant != GNT_NONE) begin
      last_warp <= rb_warp_selector;
    end
  end

  rf_fwd_mux u_fwd_0 (
    .fwd_en    (fwd_en),
    .rd_addr   (rd_addr_0),
    .rd_mask   (rd_mask),
    .wb_addr   (wb_addr),
    .wb_mask   (wb_mask),
    .wb_data   (wb_data),
    .rb_rdata  (rb_rdata_0),
    .lane_data (fwd_data_0)
  );

  rf_fwd_mux u_fwd_1 (
    .fwd_en    (fwd_en),
    .rd_addr   (rd_addr_1),
    .rd_mask   (rd_mask),
    .wb_addr   (wb_addr),
    .wb_mask   (wb_mask),
    .wb_data   (wb_data),
    .rb_rdata  (rb_rdata_1),
    .lane_data (fwd_data_1)
  );

  // Response stage: capture operand data on a read grant; reset drops any
  // response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_warp   <= '0;
      rsp_data_0 <= '0;
      rsp_data_1 <= '0;
    end else begin
      rsp_valid <= rd_gnt;
      if (rd_gnt) begin
        rsp_warp   <= rd_warp;
        rsp_data_0 <= fwd_data_0;
        rsp_data_1 <= fwd_data_1;
      end
    end
  end

endmodule
